// File: rtl/serial_subtractor_if.sv
// Start/busy/done bus between the float control FSM and the bit-serial subtractor.
// state_dbg mirrors the subtractor FSM state for checkers and debug.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;
    logic [1:0]       state_dbg;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf, zero, state_dbg
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf, zero, state_dbg
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b, LSB first, one full-adder cell).
// Optional ovf/zero flags are built only when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    // Handshake: start is sampled only while idle (busy=0); an accepted start
    // raises busy for WIDTH+1 cycles, done pulses for exactly one cycle at the
    // end, and diff/borrow/ovf/zero hold their value until the next accept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_full;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             carry_nxt;
    logic             s;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    assign s         = a_sh[0] ^ ~b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & ~b_sh[0]) | (~b_sh[0] & carry) | (a_sh[0] & carry);
    assign accept    = (state == IDLE) && bus.start;
    assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    // Final bit lands in the MSB; the WIDTH-1 bits already produced sit below it.
    assign res_full  = {s, res_sh};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b1;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            carry  <= 1'b1;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_full[WIDTH-1:1];
            carry  <= carry_nxt;
            cnt    <= cnt + CNT_W'(1);
            if (last_step) begin
                diff_q   <= res_full;
                borrow_q <= ~carry_nxt;
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic ones_seen;
    logic ovf_q;
    logic zero_q;

    // On the last step a_sh[0]/b_sh[0] are the operand sign bits and s is the result sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_seen <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (accept) begin
            ones_seen <= 1'b0;
        end else if (state == RUN) begin
            ones_seen <= ones_seen | s;
            if (last_step) begin
                ovf_q  <= (a_sh[0] ^ b_sh[0]) & (s ^ a_sh[0]);
                zero_q <= ~(ones_seen | s);
            end
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: driver tasks push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int EW    = WIDTH + 3;
`ifdef SERIAL_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: {diff, borrow, ovf, zero} and expected done cycle
  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            after_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            dc;
    if (after_done) begin
      chk("busy_after_done", 32'(sif.busy), 32'(0));
      chk("done_single_pulse", 32'(sif.done), 32'(0));
    end
    after_done = 1'b0;
    if (sif.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(1), 32'(0));
      end else begin
        e  = exp_q.pop_front();
        dc = cyc_q.pop_front();
        chk("diff",        32'(sif.diff),   32'(e[EW-1:3]));
        chk("borrow",      32'(sif.borrow), 32'(e[2]));
        chk("ovf",         32'(sif.ovf),    32'(e[1]));
        chk("zero",        32'(sif.zero),   32'(e[0]));
        chk("done_latency", 32'(cyc),       32'(dc));
      end
      after_done = 1'b1;
    end
  end

  // driver tasks
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit track, output int acc_cyc);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = a;
    sif.b     = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (track) cyc_q.push_back(acc_cyc + WIDTH);
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sif.done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] ed, input bit eb, input bit eo, input bit ez);
    int c;
    exp_q.push_back({ed, eb, FLAGS & eo, FLAGS & ez});
    issue(a, b, 1'b1, c);
    wait_done();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},   32'(sif.busy),      32'(0));
    chk({tag, "_done"},   32'(sif.done),      32'(0));
    chk({tag, "_diff"},   32'(sif.diff),      32'(0));
    chk({tag, "_borrow"}, 32'(sif.borrow),    32'(0));
    chk({tag, "_ovf"},    32'(sif.ovf),       32'(0));
    chk({tag, "_zero"},   32'(sif.zero),      32'(0));
    chk({tag, "_state"},  32'(sif.state_dbg), 32'(0));
  endtask

  initial begin
    int c;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    run_op(8'h50, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op(8'h20, 8'h50, 8'hD0, 1'b1, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

    // start while busy is ignored (RUN at +3, DONE at +8)
    exp_q.push_back({8'h0F, 1'b0, 1'b0, 1'b0});
    issue(8'h10, 8'h01, 1'b1, c);
    wait_cyc(c + 3);
    sif.start = 1'b1; sif.a = 8'hFF; sif.b = 8'hFF;
    @(negedge clk);
    sif.start = 1'b0;
    wait_cyc(c + 8);
    sif.start = 1'b1; sif.a = 8'hFF; sif.b = 8'hFF;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignored_start_idle", 32'(sif.busy), 32'(0));
    chk("ignored_start_q_empty", 32'(exp_q.size()), 32'(0));

    // reset mid-operation aborts without a done pulse
    issue(8'h50, 8'h20, 1'b0, c);
    wait_cyc(c + 4);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_stays_idle", 32'(sif.busy), 32'(0));
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);

    // flag cases and all-ones operands
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op(8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);

    // reset pulse while idle after an operation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("idlerst");

    repeat (3) @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor for the float datapath: computes DIFF = A − B one bit per clock, LSB first.
- Each step uses a single full-adder cell with a registered carry: a + ~b + 1, carry preset to 1.
- Serves exponent-difference and mantissa-subtract paths where area matters more than latency.
- start/busy/done handshake toward the float control FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; diff/borrow valid
- diff  output  WIDTH  a − b mod 2^WIDTH; held until next accepted start
- borrow  output  1  1 when a < b unsigned (inverted final carry); held like diff
- ovf  output  1  signed overflow (see Optional Feature)
- zero  output  1  diff == 0 (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high, checked before all other logic.
- Reset values: state=IDLE; busy, done, borrow, ovf and zero = 0; diff = 0; internal shift regs = 0; carry = 1; counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 → latch a, b into shift regs; carry←1; counter←0; → RUN. start=0 → stay.
- RUN: at edges E1..E(WIDTH), step i computes:
  - s = a_sh[0] ^ ~b_sh[0] ^ carry
  - carry ← (a&~b)|(~b&carry)|(a&carry)
  - shift s into result MSB and shift both operand regs right
  - counter++
- RUN exit: when counter reaches WIDTH−1 at edge E(WIDTH) → DONE.
- DONE: for the cycle after E(WIDTH):
  - done=1
  - diff = full result
  - borrow = ~carry
  - state → IDLE at E(WIDTH+1)
- Latency: done high exactly WIDTH cycles after the accept edge; busy high WIDTH+1 cycles; next start is accepted no earlier than E(WIDTH+1).
- start while busy (RUN or DONE): ignored, no queueing, a/b not sampled.
- diff, borrow, ovf and zero registers update only at the DONE transition. Between operations they hold the last result.
- Reset mid-operation: abort, return to IDLE, all outputs revert to reset values the cycle after rst is sampled high; no done pulse.
- rst and start asserted on the same edge: rst wins.
- Boundary cases:
  - a=b gives diff=0, borrow=0.
  - 0 − 1 gives all-ones, borrow=1.
  - Operands of all-ones are handled without special cases.

Optional Feature:
- Macro: SERIAL_SUB_FLAGS_EN.
- Defined:
  - ovf = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]), i.e. carry into MSB XOR carry out.
  - zero = sticky OR of all result bits, inverted.
  - Both registered and valid with done, held like diff.
- Undefined: ovf and zero tied to 0; no flag logic synthesised; ports remain.

Test Plan (WIDTH=8):
- rst held 2 cycles, then released → busy=0, done=0, diff=0x00, borrow=0. Reset also pulsed while idle after an operation → same values.
- a=0x50, b=0x20, start 1 cycle → done exactly 8 cycles after accept edge; diff=0x30, borrow=0, busy low the cycle after done.
- a=0x20, b=0x50 → diff=0xD0, borrow=1. Then a=0x00, b=0x01 → diff=0xFF, borrow=1.
- Start a=0x10, b=0x01. Assert start again with a=0xFF, b=0xFF at cycles 3 and 8 after accept → ignored; diff=0x0F, single done pulse.
- Start a=0x50, b=0x20; rst at cycle 4 → busy=0, no done, diff=0x00. Fresh start a=0x05, b=0x03 → diff=0x02 after 8 cycles.
- With SERIAL_SUB_FLAGS_EN defined:
  - 0x80 − 0x01 → diff=0x7F, ovf=1, zero=0.
  - 0x33 − 0x33 → diff=0x00, zero=1, ovf=0, borrow=0.
- Without SERIAL_SUB_FLAGS_EN: same two cases give ovf=0, zero=0.
